// File: rtl/ppu_pkg.sv
// Shared constants, types and helpers for the NES background renderer with
// attribute lookup, writable palette and horizontal scroll.
package ppu_pkg;

  localparam int          NES_W    = 256;
  localparam int          NES_H    = 240;
  localparam logic [10:0] AT_BASE  = 11'h3C0;
  localparam int          PIPE_LAT = 5;

  typedef logic [3:0] pal_idx_t;
  typedef logic [8:0] nes_x_t;

  // Pick the 2-bit palette group of one 16x16 quadrant out of an attribute byte.
  function automatic logic [1:0] attr_sel(input logic [7:0] attr_byte,
                                          input logic [1:0] quad);
    logic [1:0] sel;
    case (quad)
      2'b00:   sel = attr_byte[1:0];
      2'b01:   sel = attr_byte[3:2];
      2'b10:   sel = attr_byte[5:4];
      2'b11:   sel = attr_byte[7:6];
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ppu_palette.sv
// 16-entry colour register file: one synchronous write port and a
// combinational read port, so a same-cycle read of a written entry sees the old value.
module ppu_palette
  import ppu_pkg::*;
#(
  parameter int NB = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  pal_idx_t      waddr_i,
  input  logic [NB-1:0] wdata_i,
  input  pal_idx_t      raddr_i,
  output logic [NB-1:0] rdata_o
);

  logic [NB-1:0] mem_q [16];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ppu_bg_pal.sv
// Background renderer: 5-edge fixed-latency pipeline from VGA position to
// palette colour, with syncs delayed alongside the pixels.
module ppu_bg_pal
  import ppu_pkg::*;
#(
  parameter int   C_MEMW       = 8,
  parameter int   C_NB_RED     = 2,
  parameter int   C_NB_GREEN   = 2,
  parameter int   C_NB_BLUE    = 2,
  parameter int   C_SCALE_LOG2 = 1,
  parameter int   C_VIS_ROWS   = 480,
  parameter logic C_SYNC_IDLE  = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      visible,
  input  logic [9:0]                                col,
  input  logic [9:0]                                row,
  input  logic                                      hsync_in,
  input  logic                                      vsync_in,
  input  logic [8:0]                                scroll_x,
  input  logic                                      pal_we,
  input  logic [3:0]                                pal_addr,
  input  logic [C_NB_RED+C_NB_GREEN+C_NB_BLUE-1:0]  pal_wdata,
  output logic [10:0]                               addr_ntable,
  input  logic [C_MEMW-1:0]                         d_ntable,
  output logic [10:0]                               addr_atable,
  input  logic [C_MEMW-1:0]                         d_atable,
  output logic [10:0]                               addr_ptable,
  input  logic [C_MEMW-1:0]                         d_ptable0,
  input  logic [C_MEMW-1:0]                         d_ptable1,
  output logic [C_NB_RED-1:0]                       red,
  output logic [C_NB_GREEN-1:0]                     green,
  output logic [C_NB_BLUE-1:0]                      blue,
  output logic                                      hsync,
  output logic                                      vsync
);

  localparam int          NB    = C_NB_RED + C_NB_GREEN + C_NB_BLUE;
  localparam logic [10:0] IMG_W = 11'(NES_W << C_SCALE_LOG2);
  localparam logic [10:0] IMG_H = 11'(NES_H << C_SCALE_LOG2);

  nes_x_t     scroll_q, scroll_d;
  nes_x_t     x_s;
  logic [7:0] y_s;
  logic       in_img_s;

  nes_x_t     x1_q;
  logic [7:0] y1_q;
  logic       img1_q, vis1_q, hs1_q, vs1_q;

  logic [4:0] xh2_q;
  logic [2:0] fx2_q;
  logic [3:0] yh2_q;
  logic [2:0] fy2_q;
  logic       img2_q, vis2_q, hs2_q, vs2_q;

  logic [2:0] fx3_q;
  logic [1:0] quad3_q;
  logic       img3_q, vis3_q, hs3_q, vs3_q;

  logic [1:0] pix_s;
  logic [1:0] attr_s;
  pal_idx_t   idx_s;

  pal_idx_t   idx4_q;
  logic       img4_q, vis4_q, hs4_q, vs4_q;

  pal_idx_t   pal_raddr_s;
  logic [NB-1:0] pal_rdata_s;
  logic [NB-1:0] rgb_q, rgb_d;
  logic       hsync_q, vsync_q;

  // Scroll only moves on the first blank row so a frame never tears.
  always_comb begin
    scroll_d = scroll_q;
    if (row == 10'(C_VIS_ROWS) && col == 10'd0) begin
      scroll_d = scroll_x;
    end else begin
      scroll_d = scroll_q;
    end
  end

  assign x_s      = nes_x_t'((col >> C_SCALE_LOG2) + {1'b0, scroll_q});
  assign y_s      = 8'(row >> C_SCALE_LOG2);
  assign in_img_s = visible && ({1'b0, col} < IMG_W) && ({1'b0, row} < IMG_H);

  // Stages P1..P3 carry only the coordinate bits later stages still consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scroll_q <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      img1_q   <= 1'b0;
      vis1_q   <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      xh2_q    <= '0;
      fx2_q    <= '0;
      yh2_q    <= '0;
      fy2_q    <= '0;
      img2_q   <= 1'b0;
      vis2_q   <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      fx3_q    <= '0;
      quad3_q  <= '0;
      img3_q   <= 1'b0;
      vis3_q   <= 1'b0;
      hs3_q    <= 1'b0;
      vs3_q    <= 1'b0;
    end else begin
      scroll_q <= scroll_d;
      x1_q     <= x_s;
      y1_q     <= y_s;
      img1_q   <= in_img_s;
      vis1_q   <= visible;
      hs1_q    <= hsync_in;
      vs1_q    <= vsync_in;
      xh2_q    <= x1_q[8:4];
      fx2_q    <= x1_q[2:0];
      yh2_q    <= y1_q[7:4];
      fy2_q    <= y1_q[2:0];
      img2_q   <= img1_q;
      vis2_q   <= vis1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      fx3_q    <= fx2_q;
      quad3_q  <= {yh2_q[0], xh2_q[0]};
      img3_q   <= img2_q;
      vis3_q   <= vis2_q;
      hs3_q    <= hs2_q;
      vs3_q    <= vs2_q;
    end
  end

  assign addr_ntable = {x1_q[8], y1_q[7:3], x1_q[7:3]};
  assign addr_ptable = {d_ntable, fy2_q};
  assign addr_atable = AT_BASE | {xh2_q[4], 4'b0000, yh2_q[3:1], xh2_q[3:1]};

  // Pattern bytes hold the leftmost pixel in the MSB; pixel 0 is the backdrop.
  always_comb begin
    pix_s  = {d_ptable1[~fx3_q], d_ptable0[~fx3_q]};
    attr_s = attr_sel(d_atable, quad3_q);
    idx_s  = 4'd0;
    if (pix_s == 2'd0) begin
      idx_s = 4'd0;
    end else begin
      idx_s = {attr_s, pix_s};
    end
  end

  // Output stage: border pixels fall back to entry 0, blanking forces black.
  always_comb begin
    pal_raddr_s = 4'd0;
    rgb_d       = '0;
    if (img4_q) begin
      pal_raddr_s = idx4_q;
    end else begin
      pal_raddr_s = 4'd0;
    end
    if (vis4_q) begin
      rgb_d = pal_rdata_s;
    end else begin
      rgb_d = '0;
    end
  end

  ppu_palette #(
    .NB (NB)
  ) u_palette (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (pal_wdata),
    .raddr_i (pal_raddr_s),
    .rdata_o (pal_rdata_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx4_q  <= '0;
      img4_q  <= 1'b0;
      vis4_q  <= 1'b0;
      hs4_q   <= 1'b0;
      vs4_q   <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= C_SYNC_IDLE;
      vsync_q <= C_SYNC_IDLE;
    end else begin
      idx4_q  <= idx_s;
      img4_q  <= img3_q;
      vis4_q  <= vis3_q;
      hs4_q   <= hs3_q;
      vs4_q   <= vs3_q;
      rgb_q   <= rgb_d;
      hsync_q <= hs4_q;
      vsync_q <= vs4_q;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hsync              = hsync_q;
  assign vsync              = vsync_q;

endmodule

// File: tb/tb_ppu_bg_pal.sv
// Self-checking bench for ppu_bg_pal: directed vectors plus random stimulus
// against a frame-level reference model of tiles, attributes and palette.
module tb_ppu_bg_pal;
  import ppu_pkg::*;

  localparam int S = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        visible = 1'b0;
  logic [9:0]  col = 10'd0;
  logic [9:0]  row = 10'd0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [8:0]  scroll_x = 9'd0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = 4'd0;
  logic [5:0]  pal_wdata = 6'd0;
  logic [10:0] addr_ntable, addr_atable, addr_ptable;
  logic [7:0]  d_ntable, d_atable, d_ptable0, d_ptable1;
  logic [1:0]  red, green, blue;
  logic        hsync, vsync;

  ppu_bg_pal #(
    .C_MEMW(8), .C_NB_RED(2), .C_NB_GREEN(2), .C_NB_BLUE(2),
    .C_SCALE_LOG2(S), .C_VIS_ROWS(480), .C_SYNC_IDLE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .visible(visible), .col(col), .row(row),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .scroll_x(scroll_x),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .addr_ntable(addr_ntable), .d_ntable(d_ntable),
    .addr_atable(addr_atable), .d_atable(d_atable),
    .addr_ptable(addr_ptable), .d_ptable0(d_ptable0), .d_ptable1(d_ptable1),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync)
  );

  always #10 clk = ~clk;

  logic [7:0] ntab [2048];
  logic [7:0] pt0  [2048];
  logic [7:0] pt1  [2048];

  always @(posedge clk) begin
    d_ntable  <= ntab[addr_ntable];
    d_atable  <= ntab[addr_atable];
    d_ptable0 <= pt0[addr_ptable];
    d_ptable1 <= pt1[addr_ptable];
  end

  typedef struct {
    int       col;
    int       row;
    bit       vis;
    bit       hs;
    bit       vs;
    int       scroll;
    bit       use_tbl;
    bit [5:0] tbl;
  } ent_t;

  typedef struct {
    int       col;
    int       row;
    bit       vis;
    bit       hs;
    bit [5:0] exp;
  } vec_t;

  ent_t     hist[$];
  bit [5:0] pal_m [16];
  int       scroll_m = 0;
  int       tests = 0;
  int       fails = 0;
  bit       use_tbl_g = 1'b0;
  bit [5:0] tbl_g = 6'd0;
  vec_t     vt [10];

  function automatic int nt_addr(ent_t e);
    int x, py;
    x  = ((e.col >> S) + e.scroll) % 512;
    py = (e.row >> S) % 256;
    return (x / 256) * 1024 + (py / 8) * 32 + (x % 256) / 8;
  endfunction

  function automatic bit [5:0] model_rgb(ent_t e);
    int x, px, py, nt, xl, tile, pa, b, pix, sh, attr, idx;
    if (!e.vis) return 6'd0;
    if (e.col >= (NES_W << S) || e.row >= (NES_H << S)) return pal_m[0];
    px   = e.col >> S;
    py   = e.row >> S;
    x    = (px + e.scroll) % 512;
    nt   = x / 256;
    xl   = x % 256;
    tile = int'(ntab[nt * 1024 + (py / 8) * 32 + xl / 8]);
    pa   = tile * 8 + py % 8;
    b    = 7 - xl % 8;
    pix  = 2 * int'(pt1[pa][b]) + int'(pt0[pa][b]);
    sh   = 4 * ((py / 16) % 2) + 2 * ((xl / 16) % 2);
    attr = (int'(ntab[nt * 1024 + 960 + (py / 32) * 8 + xl / 32]) >> sh) % 4;
    idx  = (pix == 0) ? 0 : attr * 4 + pix;
    return pal_m[idx];
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // One pixel clock: record the sampled inputs, predict the output due after this edge.
  task automatic tick();
    ent_t     e, o;
    bit [5:0] exp_rgb;
    bit       exp_hs, exp_vs;
    e = '{col: int'(col), row: int'(row), vis: visible, hs: hsync_in, vs: vsync_in,
          scroll: scroll_m, use_tbl: use_tbl_g, tbl: tbl_g};
    hist.push_back(e);
    if (row == 10'd480 && col == 10'd0) scroll_m = int'(scroll_x);
    if (hist.size() > PIPE_LAT) void'(hist.pop_front());
    if (hist.size() == PIPE_LAT) begin
      o       = hist[0];
      exp_rgb = o.use_tbl ? o.tbl : model_rgb(o);
      exp_hs  = o.hs;
      exp_vs  = o.vs;
    end else begin
      exp_rgb = 6'd0;
      exp_hs  = 1'b0;
      exp_vs  = 1'b0;
    end
    if (pal_we) pal_m[pal_addr] = pal_wdata;
    @(posedge clk);
    #1;
    check("rgb", int'({red, green, blue}), int'(exp_rgb));
    check("hsync", int'(hsync), int'(exp_hs));
    check("vsync", int'(vsync), int'(exp_vs));
    check("addr_ntable", int'(addr_ntable), nt_addr(e));
    pal_we    = 1'b0;
    use_tbl_g = 1'b0;
  endtask

  task automatic px(input int c, input int r, input bit v, input bit h,
                    input bit t, input bit [5:0] x);
    col       = 10'(c);
    row       = 10'(r);
    visible   = v;
    hsync_in  = h;
    use_tbl_g = t;
    tbl_g     = x;
    tick();
  endtask

  task automatic pal_wr(input int a, input bit [5:0] d);
    pal_we    = 1'b1;
    pal_addr  = 4'(a);
    pal_wdata = d;
    px(700, 490, 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) px(700, 490, 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      int c, r;
      c = $urandom_range(0, 799);
      r = $urandom_range(0, 524);
      if (i % 37 == 5) begin
        c = 0;
        r = 480;
      end
      scroll_x = 9'($urandom_range(0, 511));
      vsync_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        pal_we    = 1'b1;
        pal_addr  = 4'($urandom_range(0, 15));
        pal_wdata = 6'($urandom_range(0, 63));
      end
      px(c, r, (c < 640 && r < 480), 1'($urandom_range(0, 1)), 1'b0, 6'd0);
    end
    vsync_in = 1'b0;
  endtask

  initial begin
    vt[0] = '{64,  0,   1'b1, 1'b0, 6'h3F};
    vt[1] = '{66,  0,   1'b1, 1'b0, 6'h01};
    vt[2] = '{0,   0,   1'b1, 1'b0, 6'h05};
    vt[3] = '{32,  0,   1'b1, 1'b1, 6'h0A};
    vt[4] = '{0,   32,  1'b1, 1'b1, 6'h12};
    vt[5] = '{32,  32,  1'b1, 1'b0, 6'h2B};
    vt[6] = '{512, 10,  1'b1, 1'b0, 6'h01};
    vt[7] = '{100, 500, 1'b1, 1'b0, 6'h01};
    vt[8] = '{64,  0,   1'b0, 1'b0, 6'h00};
    vt[9] = '{2,   0,   1'b1, 1'b0, 6'h11};

    for (int i = 0; i < 2048; i++) begin
      ntab[i] = 8'($urandom);
      pt0[i]  = 8'($urandom);
      pt1[i]  = 8'($urandom);
    end
    ntab[0] = 8'h01; ntab[2] = 8'h01; ntab[64] = 8'h01; ntab[66] = 8'h01;
    ntab[4] = 8'h02;
    ntab[11'h3C0] = 8'b11_10_01_00;
    ntab[11'h3C1] = 8'h01;
    pt0[8]  = 8'hC0; pt1[8]  = 8'h40;
    pt0[16] = 8'h80; pt1[16] = 8'h80;
    for (int i = 0; i < 16; i++) pal_m[i] = 6'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    pal_wr(0, 6'h01);  pal_wr(1, 6'h05);  pal_wr(5, 6'h0A);
    pal_wr(9, 6'h12);  pal_wr(13, 6'h2B); pal_wr(7, 6'h3F);
    pal_wr(3, 6'h11);

    for (int i = 0; i < 10; i++) px(vt[i].col, vt[i].row, vt[i].vis, vt[i].hs, 1'b1, vt[i].exp);
    flush(4);

    // Palette write on the edge that reads the same entry.
    px(2, 0, 1'b1, 1'b0, 1'b1, 6'h11);
    px(2, 0, 1'b1, 1'b0, 1'b1, 6'h2E);
    px(2, 0, 1'b1, 1'b0, 1'b1, 6'h2E);
    px(2, 0, 1'b1, 1'b0, 1'b1, 6'h2E);
    pal_we = 1'b1; pal_addr = 4'd3; pal_wdata = 6'h2E;
    px(700, 490, 1'b0, 1'b0, 1'b0, 6'd0);
    flush(4);

    // Scroll wrap and frame-only latching.
    scroll_x = 9'd500;
    px(0, 480, 1'b0, 1'b0, 1'b0, 6'd0);
    px(40, 0, 1'b1, 1'b0, 1'b0, 6'd0);
    check("scroll_wrap_x8", int'(addr_ntable), 32'h001);
    px(22, 0, 1'b1, 1'b0, 1'b0, 6'd0);
    check("scroll_wrap_x511", int'(addr_ntable), 32'h41F);
    scroll_x = 9'd7;
    px(0, 100, 1'b1, 1'b0, 1'b0, 6'd0);
    px(40, 0, 1'b1, 1'b0, 1'b0, 6'd0);
    check("scroll_hold", int'(addr_ntable), 32'h001);
    px(0, 480, 1'b0, 1'b0, 1'b0, 6'd0);
    px(40, 0, 1'b1, 1'b0, 1'b0, 6'd0);
    check("scroll_latch", int'(addr_ntable), 32'h003);
    flush(4);

    rand_run(300);
    flush(4);

    // Asynchronous reset in the middle of active border pixels.
    pal_wr(0, 6'h3F);
    for (int i = 0; i < 5; i++) px(600, 10, 1'b1, 1'b0, 1'b0, 6'd0);
    rst = 1'b0;
    #1;
    check("rst_rgb", int'({red, green, blue}), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    hist.delete();
    for (int i = 0; i < 16; i++) pal_m[i] = 6'd0;
    scroll_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    pal_we = 1'b1; pal_addr = 4'd0; pal_wdata = 6'h15;
    for (int i = 0; i < 6; i++) px(600, 10, 1'b1, 1'b0, 1'b0, 6'd0);

    rand_run(200);
    flush(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ppu_bg_pal.md
Name: ppu_bg_pal

Overview:
- Next-generation NES background renderer, replacing the plain name-table/pattern-table ppu.
- Adds attribute-table lookup, a writable 16-entry palette and horizontal scroll across two name tables.
- Adds pixel-scale and colour-width parameters and uses synchronous (clocked) ROMs in a fixed-latency pipeline.
- Sits between vga_sync and the top-level RGB/sync output registers, and delays hsync/vsync to stay aligned with the pixels.

Parameters:
- C_MEMW, 8: ROM data width.
- C_NB_RED, 2: red bits.
- C_NB_GREEN, 2: green bits.
- C_NB_BLUE, 2: blue bits.
- C_SCALE_LOG2, 1: VGA pixels per NES pixel, log2; legal values 0..2.
- C_VIS_ROWS, 480: first non-visible VGA row; scroll is latched on this row.
- C_SYNC_IDLE, 1: reset value of the hsync/vsync outputs.

Ports:
- clk  in  1  pixel clock (50 MHz)
- rst  in  1  asynchronous reset, active-low
- visible  in  1  from vga_sync
- col  in  10  VGA column
- row  in  10  VGA row
- hsync_in  in  1  raw hsync from vga_sync
- vsync_in  in  1  raw vsync from vga_sync
- scroll_x  in  9  horizontal scroll in NES pixels, 0..511
- pal_we  in  1  palette write strobe
- pal_addr  in  4  palette entry to write
- pal_wdata  in  NB=C_NB_RED+C_NB_GREEN+C_NB_BLUE  packed {R,G,B}
- addr_ntable  out  11  name-table read address, tile port
- d_ntable  in  C_MEMW  data for addr_ntable, 1-clk latency
- addr_atable  out  11  name-table read address, attribute port
- d_atable  in  C_MEMW  data for addr_atable, 1-clk latency
- addr_ptable  out  11  pattern-table address, shared by both planes
- d_ptable0  in  C_MEMW  plane 0 data, 1-clk latency
- d_ptable1  in  C_MEMW  plane 1 data, 1-clk latency
- red  out  C_NB_RED  red output
- green  out  C_NB_GREEN  green output
- blue  out  C_NB_BLUE  blue output
- hsync  out  1  delayed sync
- vsync  out  1  delayed sync

Behaviour:
- Reset (rst=0, asynchronous):
  - All pipeline registers, scroll_q and the palette clear to 0.
  - red, green, blue are 0; hsync and vsync are C_SYNC_IDLE.
  - Releasing reset mid-frame needs no resync: outputs are valid after 5 edges.
- Scroll latch: scroll_q <= scroll_x only on an edge where row==C_VIS_ROWS and col==0. Scroll therefore changes only between frames.
- Stage P1 (edge n) registers:
  - x = ((col>>C_SCALE_LOG2) + scroll_q) mod 512, 9 bits.
  - y = row>>C_SCALE_LOG2, 8 bits.
  - in_img = visible & (col < 256<<S) & (row < 240<<S).
  - visible, hsync_in, vsync_in.
- Address and stage logic:
  - addr_ntable = {x[8], y[7:3], x[7:3]} from P1.
  - Edge n+1: P2 <- P1.
  - addr_ptable = {d_ntable, P2.y[2:0]}.
  - addr_atable = {P2.x[8], 4'b1111, P2.y[7:5], P2.x[7:5]}, i.e. 0x3C0 + (y/32)*8 + x/32.
  - Edge n+2: P3 <- P2.
  - Pixel value: pix = {d_ptable1[7-fx], d_ptable0[7-fx]}, where fx = P3.x[2:0]; the MSB is the leftmost pixel.
  - Attribute select uses q = {P3.y[4], P3.x[4]}: 00 -> d_atable[1:0], 01 -> [3:2], 10 -> [5:4], 11 -> [7:6].
  - Palette index: idx = (pix==0) ? 0 : {attr, pix}. Index 0 is the universal backdrop.
  - Edge n+3: P4 <- idx, in_img, visible, syncs.
- Output (edge n+4):
  - If !P4.visible: RGB = 0.
  - Else if !P4.in_img: RGB = palette[0].
  - Else: RGB = palette[P4.idx].
  - hsync and vsync come from P4.
  - Fixed latency: inputs sampled at edge n appear after edge n+4, with no stalls.
- Palette:
  - Write takes effect on the edge where pal_we=1.
  - A read of the same entry in that cycle returns the old value.
- Wrap-around: x wraps modulo 512, so name table 1 wraps back to table 0.
- Edge cases:
  - The y range 240..255 is never reached while in_img=1.
  - Address outputs toggle freely during blanking; that is harmless.

Decomposition:
- Package ppu_pkg holds:
  - constants NES_W=256, NES_H=240, AT_BASE=11'h3C0, PIPE_LAT=5.
  - typedefs pal_idx_t (4 bits) and nes_x_t (9 bits).
- Sub-module ppu_palette: 16 x NB register file with one synchronous write port and a combinational read, reset to 0.

Test Plan:
- Reset: assert rst low mid-line with outputs active -> immediately RGB=0 and hsync=vsync=1, with no clock edge needed. Release -> first valid pixel 5 edges later.
- Latency and colour (C_SCALE_LOG2=1):
  - Setup: write palette[7]=6'h3F; ntable[0]=8'h02; atable[0x3C0]=8'h01; ptable tile 2 row 0 planes = 8'h80/8'h80.
  - Stimulus: col=0, row=0, visible=1 at edge n.
  - Expected: RGB=3/3/3 after edge n+4; col=2 gives palette[0].
- Scroll wrap:
  - Setup: scroll_x=500 latched at row 480, col 0.
  - Stimulus: col=40 -> x=(20+500) mod 512=8.
  - Expected: addr_ntable=11'h001 (table 0, tile 1); col=22 -> x=511 -> addr_ntable=11'h41F.
- Attribute quadrant:
  - Setup: atable[0x3C0]=8'b11_10_01_00.
  - Expected: pixels at NES (0,0)/(16,0)/(0,16)/(16,16) with pix=1 select indices 1, 5, 9 and 13.
- Border and blanking:
  - col=512, row=10, visible=1 -> RGB=palette[0].
  - visible=0 -> RGB=0.
  - Stimulus: hsync_in pulse at edge n -> hsync pulse after edge n+4, same width.
- Palette and scroll corner cases:
  - pal_we to entry 3 on the same edge P4 reads entry 3 -> output shows the old value, the new value from the next pixel.
  - Expected: scroll_x change at row 100 leaves scroll_q unchanged until row 480.
